// File: rtl/pipe_ctrl.sv
// Pipeline issue controller: free-run / single-step / halt-drain FSM with issue and stall counters.
// Optional stall-cycle performance counter enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        run_req,
    input  logic        step_req,
    input  logic        jump_id,
    input  logic        halt_id,
    output logic        pc_we,
    output logic        ifid_stall,
    output logic        idex_bubble,
    output logic        step_ack,
    output logic        halted,
    output logic [2:0]  state,
    output logic [15:0] issue_count,
    output logic [15:0] stall_cycles
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StRun    = 3'd1,
        StStep   = 3'd2,
        StDrain  = 3'd3,
        StHalted = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic        step_q, step_d;
    logic [1:0]  drain_cnt_q, drain_cnt_d;
    logic [15:0] issue_count_q, issue_count_d;
    logic        step_edge;
    logic        issue;

    assign step_edge = step_req & ~step_q;
    assign step_d    = step_req;

    always_comb begin
        pc_we       = 1'b0;
        ifid_stall  = 1'b1;
        idex_bubble = 1'b1;
        step_ack    = 1'b0;
        halted      = 1'b0;
        state_d     = StIdle;
        drain_cnt_d = 2'd0;
        case (state_q)
            StIdle: begin
                if (run_req) begin
                    state_d = StRun;
                end else if (step_edge) begin
                    state_d = StStep;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun, StStep: begin
                // A simultaneous jump and halt resolves as a halt.
                pc_we       = ~halt_id;
                ifid_stall  = 1'b0;
                idex_bubble = jump_id | halt_id;
                step_ack    = (state_q == StStep);
                if (halt_id) begin
                    state_d = StDrain;
                end else if ((state_q == StRun) && run_req) begin
                    state_d = StRun;
                end else begin
                    state_d = StIdle;
                end
            end
            StDrain: begin
                if (drain_cnt_q == 2'd1) begin
                    state_d = StHalted;
                end else begin
                    state_d     = StDrain;
                    drain_cnt_d = drain_cnt_q + 2'd1;
                end
            end
            StHalted: begin
                halted  = 1'b1;
                state_d = StHalted;
            end
            default: state_d = StIdle;
        endcase
    end

    assign issue         = ((state_q == StRun) || (state_q == StStep)) && !idex_bubble;
    assign issue_count_d = issue ? (issue_count_q + 16'd1) : issue_count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            step_q        <= 1'b0;
            drain_cnt_q   <= 2'd0;
            issue_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            step_q        <= step_d;
            drain_cnt_q   <= drain_cnt_d;
            issue_count_q <= issue_count_d;
        end
    end

    assign state       = state_q;
    assign issue_count = issue_count_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [15:0] stall_cycles_q, stall_cycles_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (!pc_we && (state_q != StHalted) && (stall_cycles_q != 16'hFFFF)) begin
            stall_cycles_d = stall_cycles_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles_q <= 16'd0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
`else
    assign stall_cycles = 16'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed vector table plus hand-written reset sequences.
module tb_pipe_ctrl;

    logic        clk;
    logic        reset;
    logic        run_req, step_req, jump_id, halt_id;
    logic        pc_we, ifid_stall, idex_bubble, step_ack, halted;
    logic [2:0]  state;
    logic [15:0] issue_count, stall_cycles;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_stall;

    pipe_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .run_req      (run_req),
        .step_req     (step_req),
        .jump_id      (jump_id),
        .halt_id      (halt_id),
        .pc_we        (pc_we),
        .ifid_stall   (ifid_stall),
        .idex_bubble  (idex_bubble),
        .step_ack     (step_ack),
        .halted       (halted),
        .state        (state),
        .issue_count  (issue_count),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        run, step, jump, halt;
        logic        pc_we, ifid_stall, bubble, ack, hlt;
        logic [2:0]  st;
        logic [15:0] ic;
    } vec_t;

    vec_t vecs[23];

    function automatic vec_t mk(input logic run, input logic step, input logic jump,
                                input logic halt, input logic pw, input logic fs,
                                input logic bb, input logic ak, input logic hl,
                                input logic [2:0] st, input logic [15:0] ic);
        vec_t v;
        v.run = run; v.step = step; v.jump = jump; v.halt = halt;
        v.pc_we = pw; v.ifid_stall = fs; v.bubble = bb; v.ack = ak; v.hlt = hl;
        v.st = st; v.ic = ic;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [15:0] act,
                       input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1);
    end

    initial begin
        //            run step jmp hlt  pc  fs  bb ack hlt st  ic
        vecs[0]  = mk(0, 0, 0, 0,  0, 1, 1, 0, 0, 3'd0, 16'd0);
        vecs[1]  = mk(1, 0, 0, 0,  0, 1, 1, 0, 0, 3'd0, 16'd0);
        vecs[2]  = mk(1, 0, 0, 0,  1, 0, 0, 0, 0, 3'd1, 16'd0);
        vecs[3]  = mk(1, 0, 0, 0,  1, 0, 0, 0, 0, 3'd1, 16'd1);
        vecs[4]  = mk(1, 0, 0, 0,  1, 0, 0, 0, 0, 3'd1, 16'd2);
        vecs[5]  = mk(1, 0, 0, 0,  1, 0, 0, 0, 0, 3'd1, 16'd3);
        vecs[6]  = mk(1, 0, 0, 0,  1, 0, 0, 0, 0, 3'd1, 16'd4);
        vecs[7]  = mk(1, 0, 1, 0,  1, 0, 1, 0, 0, 3'd1, 16'd5);
        vecs[8]  = mk(1, 0, 0, 0,  1, 0, 0, 0, 0, 3'd1, 16'd5);
        vecs[9]  = mk(0, 0, 0, 0,  1, 0, 0, 0, 0, 3'd1, 16'd6);
        vecs[10] = mk(0, 1, 0, 0,  0, 1, 1, 0, 0, 3'd0, 16'd7);
        vecs[11] = mk(0, 1, 0, 0,  1, 0, 0, 1, 0, 3'd2, 16'd7);
        vecs[12] = mk(0, 1, 0, 0,  0, 1, 1, 0, 0, 3'd0, 16'd8);
        vecs[13] = mk(0, 1, 0, 0,  0, 1, 1, 0, 0, 3'd0, 16'd8);
        vecs[14] = mk(0, 0, 0, 0,  0, 1, 1, 0, 0, 3'd0, 16'd8);
        vecs[15] = mk(1, 1, 0, 0,  0, 1, 1, 0, 0, 3'd0, 16'd8);
        vecs[16] = mk(1, 1, 0, 0,  1, 0, 0, 0, 0, 3'd1, 16'd8);
        vecs[17] = mk(1, 0, 1, 1,  0, 0, 1, 0, 0, 3'd1, 16'd9);
        vecs[18] = mk(1, 1, 0, 0,  0, 1, 1, 0, 0, 3'd3, 16'd9);
        vecs[19] = mk(1, 0, 0, 0,  0, 1, 1, 0, 0, 3'd3, 16'd9);
        vecs[20] = mk(1, 1, 0, 0,  0, 1, 1, 0, 1, 3'd4, 16'd9);
        vecs[21] = mk(0, 0, 0, 0,  0, 1, 1, 0, 1, 3'd4, 16'd9);
        vecs[22] = mk(1, 1, 0, 0,  0, 1, 1, 0, 1, 3'd4, 16'd9);

        reset = 1'b1; run_req = 1'b0; step_req = 1'b0; jump_id = 1'b0; halt_id = 1'b0;
        #2;
        chk("reset_state", 0, {13'd0, state}, 16'd0);
        chk("reset_pc_we", 0, {15'd0, pc_we}, 16'd0);
        chk("reset_ifid_stall", 0, {15'd0, ifid_stall}, 16'd1);
        chk("reset_bubble", 0, {15'd0, idex_bubble}, 16'd1);
        chk("reset_step_ack", 0, {15'd0, step_ack}, 16'd0);
        chk("reset_halted", 0, {15'd0, halted}, 16'd0);
        chk("reset_issue", 0, issue_count, 16'd0);
        chk("reset_stall", 0, stall_cycles, 16'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Ten idle cycles for the stall counter.
        repeat (10) @(posedge clk);
        #1;
`ifdef PIPE_CTRL_PERF_EN
        exp_stall = 10;
`else
        exp_stall = 0;
`endif
        chk("idle10_stall", 0, stall_cycles, exp_stall[15:0]);

        for (int i = 0; i < 23; i++) begin
            run_req  = vecs[i].run;
            step_req = vecs[i].step;
            jump_id  = vecs[i].jump;
            halt_id  = vecs[i].halt;
            @(negedge clk);
            chk("pc_we", i, {15'd0, pc_we}, {15'd0, vecs[i].pc_we});
            chk("ifid_stall", i, {15'd0, ifid_stall}, {15'd0, vecs[i].ifid_stall});
            chk("idex_bubble", i, {15'd0, idex_bubble}, {15'd0, vecs[i].bubble});
            chk("step_ack", i, {15'd0, step_ack}, {15'd0, vecs[i].ack});
            chk("halted", i, {15'd0, halted}, {15'd0, vecs[i].hlt});
            chk("state", i, {13'd0, state}, {13'd0, vecs[i].st});
            chk("issue_count", i, issue_count, vecs[i].ic);
            chk("stall_cycles", i, stall_cycles, exp_stall[15:0]);
`ifdef PIPE_CTRL_PERF_EN
            if (!vecs[i].pc_we && (vecs[i].st != 3'd4)) exp_stall++;
`endif
            @(posedge clk);
            #1;
        end

        // Asynchronous reset out of HALTED, between clock edges.
        #1 reset = 1'b1;
        #1;
        chk("halted_rst_state", 0, {13'd0, state}, 16'd0);
        chk("halted_rst_halted", 0, {15'd0, halted}, 16'd0);
        chk("halted_rst_issue", 0, issue_count, 16'd0);
        chk("halted_rst_stall", 0, stall_cycles, 16'd0);
        @(posedge clk);
        #1 reset = 1'b0; run_req = 1'b1; step_req = 1'b0;
        @(posedge clk);
        #1 halt_id = 1'b1;
        @(negedge clk);
        chk("halt_run_pc_we", 0, {15'd0, pc_we}, 16'd0);
        @(posedge clk);
        #1 halt_id = 1'b0; run_req = 1'b0;
        @(posedge clk);
        #1;
        chk("drain2_state", 0, {13'd0, state}, 16'd3);
        // Asynchronous reset in the second DRAIN cycle.
        #2 reset = 1'b1;
        #1;
        chk("drain_rst_state", 0, {13'd0, state}, 16'd0);
        chk("drain_rst_ifid_stall", 0, {15'd0, ifid_stall}, 16'd1);
        chk("drain_rst_halted", 0, {15'd0, halted}, 16'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_idle", 0, {13'd0, state}, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port run_req  input  1  level; 1 = free-run issue requested.
REQ-004 SHALL have port step_req  input  1  single-step request; only its rising edge is acted on.
REQ-005 SHALL have port jump_id  input  1  decoded: instruction in IF/ID is a jump.
REQ-006 SHALL have port halt_id  input  1  decoded: instruction in IF/ID is a halt.
REQ-007 SHALL have port pc_we  output  1  PC register write enable.
REQ-008 SHALL have port ifid_stall  output  1  hold IF/ID register contents.
REQ-009 SHALL have port idex_bubble  output  1  load ID/EX with a NOP (regwrite=0).
REQ-010 SHALL have port step_ack  output  1  one-cycle pulse when a stepped issue happens.
REQ-011 SHALL have port halted  output  1  1 while in HALTED.
REQ-012 SHALL have port state  output  3  current FSM encoding.
REQ-013 SHALL have port issue_count  output  16  instructions issued into EX.
REQ-014 SHALL have port stall_cycles  output  16  performance counter (see Configuration).

Function
REQ-015 SHALL implement states IDLE=0, RUN=1, STEP=2, DRAIN=3, HALTED=4; encodings 5-7 SHALL go to IDLE next cycle.
REQ-016 SHALL register step_req into step_q each cycle; step_edge = step_req & ~step_q.
REQ-017 IDLE: pc_we=0, ifid_stall=1, idex_bubble=1; next state RUN if run_req, else STEP if step_edge, else IDLE.
REQ-018 run_req and step_edge both high in IDLE SHALL select RUN; the step is discarded and no step_ack is given.
REQ-019 RUN: pc_we=~halt_id, ifid_stall=0, idex_bubble=jump_id|halt_id; next state DRAIN if halt_id, else IDLE if ~run_req, else RUN.
REQ-020 STEP: same outputs as RUN, plus step_ack=1; next state DRAIN if halt_id, else IDLE; step_req activity during STEP SHALL be ignored.
REQ-021 Jump in RUN/STEP: idex_bubble=1 in the same cycle (combinational), pc_we stays 1, no state change caused by the jump.
REQ-022 DRAIN: pc_we=0, ifid_stall=1, idex_bubble=1 for exactly 2 cycles (2-bit counter), then HALTED.
REQ-023 HALTED: same outputs as DRAIN, halted=1; leaves only by reset; run_req/step_req ignored.
REQ-024 halt_id and jump_id both high SHALL be treated as halt.
REQ-025 issue_count SHALL increment by 1 in each RUN/STEP cycle with idex_bubble=0; it wraps 0xFFFF -> 0x0000.
REQ-026 All outputs except issue_count, stall_cycles and state SHALL be combinational from state, jump_id and halt_id only.

Reset
REQ-027 On reset: state=IDLE, step_q=0, drain counter=0, issue_count=0, stall_cycles=0; hence pc_we=0, ifid_stall=1, idex_bubble=1, step_ack=0, halted=0.
REQ-028 Reset asserted mid-DRAIN or in HALTED SHALL return to IDLE immediately, without waiting for a clock edge.

Configuration
REQ-029 Macro PIPE_CTRL_PERF_EN defined: stall_cycles SHALL increment in every cycle with pc_we=0 and state!=HALTED, saturating at 0xFFFF.
REQ-030 Macro PIPE_CTRL_PERF_EN undefined: stall_cycles SHALL be constant 0 and no counter register SHALL be synthesised.

Verification
REQ-031 Reset, then run_req=1 with no jump/halt for 5 cycles -> state=1, pc_we=1 every cycle, issue_count=5.
REQ-032 In RUN, jump_id=1 for one cycle -> idex_bubble=1 in that cycle only, pc_we=1, issue_count not incremented that cycle.
REQ-033 In IDLE, step_req held high 4 cycles -> exactly one STEP cycle, one step_ack pulse, issue_count +1, back to IDLE.
REQ-034 In RUN, halt_id=1 -> pc_we=0 that cycle, DRAIN for 2 cycles, then halted=1 held with run_req=1 and step_req toggling; reset -> state=0, halted=0.
REQ-035 With PIPE_CTRL_PERF_EN: reset then 10 cycles IDLE -> stall_cycles=10; without the macro -> stall_cycles=0.
REQ-036 run_req and a step_req rising edge applied together in IDLE -> state=1 next cycle, step_ack never asserted.
